// File: rtl/seg_zext_adder.sv
// Pipelined segmented adder/subtractor: A (A_WIDTH) +/- zero-extended B, one SEG_WIDTH slice per stage.
// Optional macro SEG_ZEXT_ADDER_SAT_EN clamps borrowing subtracts to zero and raises sat.
module seg_zext_adder #(
  parameter int unsigned A_WIDTH   = 35,
  parameter int unsigned B_WIDTH   = 12,
  parameter int unsigned SEG_WIDTH = 12
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [A_WIDTH-1:0] a,
  input  logic [B_WIDTH-1:0] b,
  input  logic               op,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [A_WIDTH:0]   sum,
  output logic               busy,
  output logic               sat
);

  localparam int unsigned NSEG = (A_WIDTH + SEG_WIDTH - 1) / SEG_WIDTH;
  localparam int unsigned PW   = NSEG * SEG_WIDTH + 1;
  localparam int unsigned LAST = NSEG - 1;

  // Per-stage token: valid, op, carry/borrow out, operands (zero-padded) and partial result.
  logic [NSEG-1:0] v_q, v_d;
  logic [NSEG-1:0] op_q, op_d;
  logic [NSEG-1:0] cb_q, cb_d;
  logic [PW-1:0]   a_q [NSEG];
  logic [PW-1:0]   a_d [NSEG];
  logic [PW-1:0]   b_q [NSEG];
  logic [PW-1:0]   b_d [NSEG];
  logic [PW-1:0]   r_q [NSEG];
  logic [PW-1:0]   r_d [NSEG];

  logic                 advance_c;
  logic                 src_v, src_op, src_cb;
  logic [PW-1:0]        src_a, src_b, src_r;
  logic [SEG_WIDTH-1:0] seg_a, seg_b;
  logic [SEG_WIDTH:0]   seg_t;
  int unsigned          prv;

`ifdef SEG_ZEXT_ADDER_SAT_EN
  logic sat_q, sat_d;
`endif

  // Global stall: the whole pipe moves together whenever the output slot is free or draining.
  assign advance_c = !v_q[LAST] || out_ready;

  always_comb begin
    v_d    = '0;
    op_d   = '0;
    cb_d   = '0;
    src_v  = 1'b0;
    src_op = 1'b0;
    src_cb = 1'b0;
    src_a  = '0;
    src_b  = '0;
    src_r  = '0;
    seg_a  = '0;
    seg_b  = '0;
    seg_t  = '0;
    prv    = 0;
`ifdef SEG_ZEXT_ADDER_SAT_EN
    sat_d  = 1'b0;
`endif
    for (int unsigned k = 0; k < NSEG; k++) begin
      a_d[k] = '0;
      b_d[k] = '0;
      r_d[k] = '0;
    end
    for (int unsigned k = 0; k < NSEG; k++) begin
      prv = (k == 0) ? 0 : k - 1;
      if (k == 0) begin
        src_v  = in_valid;
        src_op = op;
        src_cb = 1'b0;
        src_a  = PW'(a);
        src_b  = PW'(b);
        src_r  = '0;
      end else begin
        src_v  = v_q[prv];
        src_op = op_q[prv];
        src_cb = cb_q[prv];
        src_a  = a_q[prv];
        src_b  = b_q[prv];
        src_r  = r_q[prv];
      end
      // Slice k: carry-in on add, borrow-in on subtract; bit SEG_WIDTH is the carry/borrow out.
      seg_a = SEG_WIDTH'(src_a >> (k * SEG_WIDTH));
      seg_b = SEG_WIDTH'(src_b >> (k * SEG_WIDTH));
      if (src_op)
        seg_t = {1'b0, seg_a} - {1'b0, seg_b} - (SEG_WIDTH + 1)'(src_cb);
      else
        seg_t = {1'b0, seg_a} + {1'b0, seg_b} + (SEG_WIDTH + 1)'(src_cb);
      v_d[k]  = src_v;
      op_d[k] = src_op;
      cb_d[k] = seg_t[SEG_WIDTH];
      a_d[k]  = src_a;
      b_d[k]  = src_b;
      r_d[k]  = src_r;
      r_d[k][k * SEG_WIDTH +: SEG_WIDTH] = seg_t[SEG_WIDTH-1:0];
      if (k == LAST) begin
        // Zero padding above A_WIDTH makes bit A_WIDTH the final carry/borrow in every geometry.
        r_d[k][PW-1] = seg_t[SEG_WIDTH];
`ifdef SEG_ZEXT_ADDER_SAT_EN
        sat_d = src_op && seg_t[SEG_WIDTH];
        if (sat_d) r_d[k] = '0;
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q  <= '0;
      op_q <= '0;
      cb_q <= '0;
      for (int unsigned k = 0; k < NSEG; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        r_q[k] <= '0;
      end
`ifdef SEG_ZEXT_ADDER_SAT_EN
      sat_q <= 1'b0;
`endif
    end else if (advance_c) begin
      v_q  <= v_d;
      op_q <= op_d;
      cb_q <= cb_d;
      for (int unsigned k = 0; k < NSEG; k++) begin
        a_q[k] <= a_d[k];
        b_q[k] <= b_d[k];
        r_q[k] <= r_d[k];
      end
`ifdef SEG_ZEXT_ADDER_SAT_EN
      sat_q <= sat_d;
`endif
    end
  end

  assign in_ready  = advance_c;
  assign out_valid = v_q[LAST];
  assign busy      = |v_q;
  assign sum       = (A_WIDTH + 1)'(r_q[LAST]);
`ifdef SEG_ZEXT_ADDER_SAT_EN
  assign sat       = sat_q;
`else
  assign sat       = 1'b0;
`endif

endmodule

// File: tb/tb_seg_zext_adder.sv
// Self-checking bench for seg_zext_adder at default geometry: directed corner cases plus random traffic
// scored against an arithmetic reference queue.
module tb_seg_zext_adder;

  localparam int unsigned AW = 35;
  localparam int unsigned BW = 12;
  localparam int unsigned SW = 12;
  localparam int unsigned LAT = 3;

  logic          clk, rst_n;
  logic          in_valid, in_ready, op, out_valid, out_ready, busy, sat;
  logic [AW-1:0] a;
  logic [BW-1:0] b;
  logic [AW:0]   sum;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [AW+1:0] exp_q[$];   // {sat, sum}
  int            in_cyc[$];
  int            out_cyc[$];
  logic [AW+1:0] held;
  logic          stall_prev = 1'b0;

  seg_zext_adder #(.A_WIDTH(AW), .B_WIDTH(BW), .SEG_WIDTH(SW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .busy(busy), .sat(sat)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Reference: exact wide arithmetic, borrow shows up as the 2^(AW+1) wrap of the difference.
  function automatic logic [AW+1:0] model(input logic [AW-1:0] x, input logic [BW-1:0] y, input logic s);
    logic [AW:0] r;
    r = s ? ({1'b0, x} - (AW + 1)'(y)) : ({1'b0, x} + (AW + 1)'(y));
`ifdef SEG_ZEXT_ADDER_SAT_EN
    if (s && (x < AW'(y))) return {1'b1, {(AW + 1){1'b0}}};
`endif
    return {1'b0, r};
  endfunction

  function automatic logic [AW-1:0] rand_a();
    case ($urandom % 4)
      0: return '0;
      1: return '1;
      default: return AW'({$urandom, $urandom});
    endcase
  endfunction

  function automatic logic [BW-1:0] rand_b();
    case ($urandom % 4)
      0: return '0;
      1: return '1;
      default: return BW'($urandom);
    endcase
  endfunction

  // Scoreboard: handshakes are judged on the falling edge, ahead of the rising edge that commits them.
  always @(negedge clk) begin
    logic [AW+1:0] e;
    cyc++;
    if (rst_n) begin
      check("busy", 64'(busy), 64'(exp_q.size() != 0));
      if (out_valid && !out_ready) begin
        if (stall_prev) check("stall_hold", 64'({sat, sum}), 64'(held));
        held = {sat, sum};
        stall_prev = 1'b1;
      end else begin
        stall_prev = 1'b0;
      end
      if (out_valid && out_ready) begin
        e = (exp_q.size() != 0) ? exp_q.pop_front() : '1;
        check("result", 64'({sat, sum}), 64'(e));
        out_cyc.push_back(cyc);
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model(a, b, op));
        in_cyc.push_back(cyc);
      end
    end else begin
      stall_prev = 1'b0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One transaction with out_ready high: verifies acceptance, exact latency and the constant result.
  task automatic directed(input string tag, input logic [AW-1:0] x, input logic [BW-1:0] y,
                          input logic s, input logic [AW:0] es, input logic esat);
    int n;
    a = x; b = y; op = s; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    check({tag, "_accept"}, 64'(in_ready), 64'd1);
    step();
    in_valid = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 10);
    check({tag, "_latency"}, 64'(n), 64'(LAT));
    check({tag, "_sum"}, 64'(sum), 64'(es));
    check({tag, "_sat"}, 64'(sat), 64'(esat));
    step();
  endtask

  initial begin
    logic [AW-1:0] ia[4];
    logic [BW-1:0] ib[4];
    logic          iop[4];
    int idx, acc, ir_last, ib0, ob0, guard;
    logic got;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; op = 1'b0;
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_sum", 64'(sum), 64'd0);
    check("rst_sat", 64'(sat), 64'd0);
    #11 rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    step();

    directed("carry_top", 35'h7FFFFFFFF, 12'h001, 1'b0, 36'h800000000, 1'b0);
    directed("carry_seg01", 35'h000000FFF, 12'hFFF, 1'b0, 36'h000001FFE, 1'b0);
`ifdef SEG_ZEXT_ADDER_SAT_EN
    directed("sub_borrow", 35'h10, 12'h20, 1'b1, 36'h0, 1'b1);
`else
    directed("sub_borrow", 35'h10, 12'h20, 1'b1, 36'hFFFFFFFF0, 1'b0);
`endif
    directed("sub_exact", 35'h123456789, 12'h789, 1'b1, 36'h123456000, 1'b0);

    // Back-to-back burst: results on consecutive cycles, each LAT after its input.
    ib0 = in_cyc.size(); ob0 = out_cyc.size();
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      a = rand_a(); b = rand_b(); op = 1'($urandom); in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
    repeat (6) step();
    check("burst_count", 64'(out_cyc.size() - ob0), 64'd8);
    for (int i = 0; i < 8; i++) begin
      check("burst_lat", 64'(out_cyc[ob0 + i] - in_cyc[ib0 + i]), 64'(LAT));
      check("burst_back2back", 64'(out_cyc[ob0 + i] - out_cyc[ob0]), 64'(i));
    end

    // Stall: offer 4 with out_ready low for 5 cycles; only the 3 pipe slots fill.
    for (int i = 0; i < 4; i++) begin
      ia[i] = rand_a(); ib[i] = rand_b(); iop[i] = 1'($urandom);
    end
    out_ready = 1'b0; idx = 0; acc = 0; ir_last = 1;
    for (int c = 0; c < 5; c++) begin
      a = ia[idx]; b = ib[idx]; op = iop[idx]; in_valid = 1'b1;
      @(negedge clk);
      got = in_ready;
      if (c == 4) ir_last = int'(in_ready);
      step();
      if (got) begin acc++; idx++; end
    end
    check("stall_accepted", 64'(acc), 64'd3);
    check("stall_in_ready", 64'(ir_last), 64'd0);
    out_ready = 1'b1; guard = 0;
    while (idx < 4 && guard < 10) begin
      a = ia[idx]; b = ib[idx]; op = iop[idx]; in_valid = 1'b1;
      @(negedge clk);
      got = in_ready;
      step();
      if (got) idx++;
      guard++;
    end
    in_valid = 1'b0;
    check("stall_last_taken", 64'(idx), 64'd4);
    repeat (6) step();
    check("stall_drained", 64'(exp_q.size()), 64'd0);

    // Reset with three tokens in flight.
    for (int i = 0; i < 3; i++) begin
      a = rand_a(); b = rand_b(); op = 1'($urandom); in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_sum", 64'(sum), 64'd0);
    exp_q.delete();
    @(negedge clk);
    #2 rst_n = 1'b1;
    ob0 = out_cyc.size();
    step();
    directed("post_rst", 35'h400000001, 12'h0FF, 1'b0, 36'h400000100, 1'b0);
    repeat (4) step();
    check("post_rst_outputs", 64'(out_cyc.size() - ob0), 64'd1);

    // Random traffic with random back-pressure.
    for (int i = 0; i < 400; i++) begin
      in_valid = ($urandom % 4) != 0;
      out_ready = ($urandom % 3) != 0;
      a = rand_a(); b = rand_b(); op = 1'($urandom);
      step();
    end
    in_valid = 1'b0; out_ready = 1'b1; guard = 0;
    while (exp_q.size() != 0 && guard < 20) begin
      step();
      guard++;
    end
    check("final_drain", 64'(exp_q.size()), 64'd0);
    check("final_idle", 64'(busy), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seg_zext_adder.md
SEG_ZEXT_ADDER -- requirements
Module: seg_zext_adder

Interface
REQ-001 SHALL have parameter A_WIDTH, default 35: width of operand A.
REQ-002 SHALL have parameter B_WIDTH, default 12: width of operand B, which is zero-extended to A_WIDTH; legal range 1..A_WIDTH.
REQ-003 SHALL have parameter SEG_WIDTH, default 12: adder segment width, one segment per pipeline stage; legal range 1..A_WIDTH; NSEG = ceil(A_WIDTH/SEG_WIDTH), which is 3 by default.
REQ-004 clk  in  1  sole clock; all state updates on the rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 in_valid  in  1  A/B/op are presented.
REQ-007 in_ready  out  1  block accepts the input this cycle.
REQ-008 a  in  A_WIDTH  operand A.
REQ-009 b  in  B_WIDTH  operand B (zero-extended).
REQ-010 op  in  1  0 = A+B, 1 = A-B.
REQ-011 out_valid  out  1  sum holds a result.
REQ-012 out_ready  in  1  downstream accepts the result.
REQ-013 sum  out  A_WIDTH+1  result; MSB = carry (add) or borrow (sub).
REQ-014 busy  out  1  at least one pipeline stage holds a valid token.
REQ-015 sat  out  1  result was clamped (only when SEG_ZEXT_ADDER_SAT_EN is defined; otherwise tied 0).

Function
REQ-016 Input transfer SHALL occur when in_valid && in_ready; output transfer SHALL occur when out_valid && out_ready.
REQ-017 Stage k (0..NSEG-1) SHALL compute sum bits [k*SEG_WIDTH +: SEG_WIDTH] (last segment truncated to A_WIDTH) using the carry/borrow registered by stage k-1; stage 0 carry-in SHALL be 0.
REQ-018 Lower result segments and upper unconsumed operand bits and op SHALL travel with the token stage-to-stage.
REQ-019 Latency SHALL be exactly NSEG cycles from input transfer to out_valid when there is no stall.
REQ-020 Subtract SHALL be A + ~zext(B) + 1 over A_WIDTH bits; sum MSB SHALL be 1 iff A < zext(B) (borrow).
REQ-021 Add SHALL never wrap: sum = A + zext(B) exactly, in A_WIDTH+1 bits.
REQ-022 Stall SHALL be global: the whole pipeline advances iff !out_valid || out_ready; in_ready SHALL equal that advance condition.
REQ-023 A full pipe SHALL sustain one result per cycle; simultaneous output and input transfers in one cycle SHALL both occur.
REQ-024 Bubbles SHALL propagate as invalid stages; results SHALL emerge in input order with no loss or duplication.
REQ-025 sum and sat SHALL hold stable while out_valid && !out_ready.
REQ-026 busy SHALL be the OR of all stage valid bits.

Reset
REQ-027 While rst_n is low, all stage valid bits SHALL clear immediately; out_valid=0, busy=0, sum=0, sat=0.
REQ-028 in_ready SHALL be 1 from the first cycle after rst_n deasserts.
REQ-029 A reset during operation SHALL discard all in-flight tokens; no result from before the reset SHALL appear afterwards.

Configuration
REQ-030 With SEG_ZEXT_ADDER_SAT_EN defined, a subtract with A < zext(B) SHALL output sum=0 and sat=1; all other results SHALL carry sat=0.
REQ-031 Without SEG_ZEXT_ADDER_SAT_EN, subtract SHALL wrap in two's complement with borrow in the MSB, and sat SHALL be constant 0.

Verification (defaults: A_WIDTH=35, B_WIDTH=12, SEG_WIDTH=12)
REQ-032 a=0x7FFFFFFFF, b=0x001, op=0 -> sum=0x800000000 with out_valid exactly 3 cycles after input transfer.
REQ-033 a=0x000000FFF, b=0xFFF, op=0 -> sum=0x000001FFE, checking carry across the segment-0/1 boundary.
REQ-034 a=0x10, b=0x20, op=1 -> without the macro sum=0xFFFFFFFF0, sat=0; with the macro sum=0, sat=1.
REQ-035 8 back-to-back inputs with out_ready=1 -> 8 results on consecutive cycles starting at cycle 3, in order; then hold out_ready=0 for 5 cycles while offering 4 more -> 3 accepted, in_ready=0, sum stable, all delivered in order after release.
REQ-036 rst_n pulsed low with 3 tokens in flight -> out_valid=0, busy=0 immediately; no stale result appears afterwards; the next input gives its correct result 3 cycles later.
